// File: rtl/lane_arbiter.sv
// Wormhole lane arbiter: drains a multilane FIFO into a one-entry output register,
// round-robin between packets, locked to one lane until that packet's tail flit.
module lane_arbiter #(
  parameter int LANES      = 2,
  parameter int DATA_WIDTH = 32,
  parameter int LANE_BITS  = $clog2(LANES)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [LANES-1:0]      empty,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [LANE_BITS-1:0]  pop_lane,
  output logic                  pop,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [LANE_BITS-1:0]  out_lane,
  output logic                  out_valid,
  input  logic                  out_ready
);

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t               state;
  logic [LANE_BITS-1:0] lock_lane;
  logic [LANE_BITS-1:0] last_grant;
  logic [LANE_BITS-1:0] rr_pick;
  logic                 space;
  logic                 tail;

  // base + off, wrapped into [0, LANES); off never exceeds LANES
  function automatic logic [LANE_BITS-1:0] lane_add(input logic [LANE_BITS-1:0] base,
                                                    input int off);
    int s;
    s = int'(base) + off;
    if (s >= LANES) s = s - LANES;
    return LANE_BITS'(s);
  endfunction

  // Scan from the farthest candidate back to the nearest so the nearest non-empty lane wins
  always_comb begin
    rr_pick = lane_add(last_grant, 1);
    for (int i = LANES; i >= 1; i--) begin
      if (!empty[lane_add(last_grant, i)]) rr_pick = lane_add(last_grant, i);
    end
  end

  assign space    = !out_valid || out_ready;
  assign pop_lane = (state == LOCKED) ? lock_lane : rr_pick;
  assign pop      = !reset && !empty[pop_lane] && space;
  assign tail     = din[DATA_WIDTH-1];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      last_grant <= LANE_BITS'(LANES - 1);
      lock_lane  <= '0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_lane   <= '0;
    end else begin
      if (pop) begin
        out_data  <= din;
        out_lane  <= pop_lane;
        out_valid <= 1'b1;
        case (state)
          IDLE: begin
            if (tail) begin
              last_grant <= pop_lane;
            end else begin
              state     <= LOCKED;
              lock_lane <= pop_lane;
            end
          end
          LOCKED: begin
            if (tail) begin
              state      <= IDLE;
              last_grant <= lock_lane;
            end
          end
          default: state <= IDLE;
        endcase
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_lane_arbiter.sv
// Bench for lane_arbiter: per-lane FIFO model feeding the DUT, packet-level reference
// model predicting pop/pop_lane and the output register each cycle.
module tb_lane_arbiter;
  localparam int L     = 2;
  localparam int W     = 32;
  localparam int LB    = $clog2(L);
  localparam int DEPTH = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic [L-1:0]  empty;
  logic [W-1:0]  din;
  logic [LB-1:0] pop_lane;
  logic          pop;
  logic [W-1:0]  out_data;
  logic [LB-1:0] out_lane;
  logic          out_valid;
  logic          out_ready;

  lane_arbiter #(.LANES(L), .DATA_WIDTH(W)) dut (
    .clk(clk), .reset(reset), .empty(empty), .din(din),
    .pop_lane(pop_lane), .pop(pop), .out_data(out_data),
    .out_lane(out_lane), .out_valid(out_valid), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  logic [W-1:0] mem [L][DEPTH];
  int rd [L];
  int wr [L];
  int cnt[L];
  int pkt_left[L];

  assign din = mem[pop_lane][rd[pop_lane]];

  always_comb begin
    empty = '0;
    for (int l = 0; l < L; l++) empty[l] = (cnt[l] == 0);
  end

  // reference model: packet owner (-1 = none), last granted lane, output register
  int           owner;
  int           rr;
  logic         m_valid;
  logic [W-1:0] m_data;
  logic [LB-1:0] m_lane;

  int n_tests = 0;
  int n_fail  = 0;
  int seq     = 0;
  logic [W-1:0]  log_d[$];
  logic [LB-1:0] log_l[$];

  task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, want, $time);
    end
  endtask

  function automatic int model_lane();
    if (owner >= 0) return owner;
    for (int k = 1; k <= L; k++)
      if (cnt[(rr + k) % L] > 0) return (rr + k) % L;
    return (rr + 1) % L;
  endfunction

  task automatic push(input int l, input logic [W-1:0] d);
    if (cnt[l] < DEPTH) begin
      mem[l][wr[l]] = d;
      wr[l] = (wr[l] + 1) % DEPTH;
      cnt[l]++;
    end
  endtask

  task automatic cycle(input logic rdy);
    int           ml;
    logic         mp;
    logic [W-1:0] f;
    @(negedge clk);
    out_ready = rdy;
    #1;
    ml = model_lane();
    mp = !reset && (cnt[ml] > 0) && (!m_valid || rdy);
    chk("pop",       W'(pop),       W'(mp));
    chk("pop_lane",  W'(pop_lane),  W'(ml));
    chk("out_valid", W'(out_valid), W'(m_valid));
    chk("out_data",  out_data,      m_data);
    chk("out_lane",  W'(out_lane),  W'(m_lane));
    if (out_valid && rdy) begin
      log_d.push_back(out_data);
      log_l.push_back(out_lane);
    end
    @(posedge clk);
    #1;
    if (mp) begin
      f = mem[ml][rd[ml]];
      rd[ml] = (rd[ml] + 1) % DEPTH;
      cnt[ml]--;
      m_data  = f;
      m_lane  = LB'(ml);
      m_valid = 1'b1;
      if (f[W-1]) begin
        owner = -1;
        rr    = ml;
      end else begin
        owner = ml;
      end
    end else if (m_valid && rdy) begin
      m_valid = 1'b0;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    #1;
    owner = -1; rr = L - 1;
    m_valid = 1'b0; m_data = '0; m_lane = '0;
    chk("rst_valid",    W'(out_valid), '0);
    chk("rst_data",     out_data,      '0);
    chk("rst_pop",      W'(pop),       '0);
    chk("rst_pop_lane", W'(pop_lane),  '0);
    cycle(1'b1);
    cycle(1'b1);
    reset = 1'b0;
  endtask

  task automatic clear_log();
    log_d.delete();
    log_l.delete();
  endtask

  task automatic chk_log(input string tag, input int idx, input logic [W-1:0] d, input int l);
    if (log_d.size() > idx) begin
      chk({tag, "_data"}, log_d[idx], d);
      chk({tag, "_lane"}, W'(log_l[idx]), W'(l));
    end else begin
      chk({tag, "_missing"}, W'(log_d.size()), W'(idx + 1));
    end
  endtask

  initial begin
    reset = 1'b1;
    out_ready = 1'b0;
    for (int l = 0; l < L; l++) begin
      rd[l] = 0; wr[l] = 0; cnt[l] = 0; pkt_left[l] = 0;
    end
    owner = -1; rr = L - 1;
    m_valid = 1'b0; m_data = '0; m_lane = '0;
    do_reset();

    // round-robin between single-flit packets
    clear_log();
    push(0, 32'h8000_0001); push(0, 32'h8000_0002);
    push(1, 32'h8000_0011); push(1, 32'h8000_0012);
    repeat (8) cycle(1'b1);
    chk("rr_count", W'(log_d.size()), W'(4));
    chk_log("rr0", 0, 32'h8000_0001, 0);
    chk_log("rr1", 1, 32'h8000_0011, 1);
    chk_log("rr2", 2, 32'h8000_0002, 0);
    chk_log("rr3", 3, 32'h8000_0012, 1);

    // wormhole: lane 0's whole packet before lane 1
    clear_log();
    push(0, 32'h0000_0001); push(0, 32'h0000_0002); push(0, 32'h8000_0003);
    push(1, 32'h8000_0010);
    repeat (8) cycle(1'b1);
    chk_log("wh0", 0, 32'h0000_0001, 0);
    chk_log("wh1", 1, 32'h0000_0002, 0);
    chk_log("wh2", 2, 32'h8000_0003, 0);
    chk_log("wh3", 3, 32'h8000_0010, 1);

    // backpressure: three stalled cycles, then full rate with no loss
    clear_log();
    for (int i = 0; i < 4; i++) push(0, 32'h8000_0100 + W'(i));
    cycle(1'b1);
    repeat (3) begin
      cycle(1'b0);
      chk("bp_pop",  W'(pop), '0);
      chk("bp_data", out_data, 32'h8000_0100);
    end
    repeat (6) cycle(1'b1);
    chk("bp_count", W'(log_d.size()), W'(4));
    for (int i = 0; i < 4; i++) chk_log("bp", i, 32'h8000_0100 + W'(i), 0);

    // locked lane 0 runs dry while lane 1 waits
    push(0, 32'h0000_0005);
    cycle(1'b1);
    push(1, 32'h8000_0020);
    repeat (3) begin
      cycle(1'b1);
      chk("stall_lane", W'(pop_lane), '0);
      chk("stall_pop",  W'(pop),      '0);
    end
    clear_log();
    push(0, 32'h8000_0006);
    repeat (5) cycle(1'b1);
    chk_log("st0", 0, 32'h8000_0006, 0);
    chk_log("st1", 1, 32'h8000_0020, 1);

    // reset while locked on lane 1: lane 0 must be granted first afterwards
    push(1, 32'h0000_0030);
    repeat (2) cycle(1'b1);
    push(0, 32'h8000_0040);
    push(1, 32'h8000_0031);
    do_reset();
    clear_log();
    repeat (5) cycle(1'b1);
    chk_log("mr0", 0, 32'h8000_0040, 0);
    chk_log("mr1", 1, 32'h8000_0031, 1);

    // randomized traffic with well-formed packets per lane
    repeat (3000) begin
      if ($urandom_range(0, 1) == 1) begin
        int l;
        logic [W-1:0] d;
        l = int'($urandom_range(0, L - 1));
        if (cnt[l] < DEPTH) begin
          if (pkt_left[l] == 0) pkt_left[l] = int'($urandom_range(1, 4));
          pkt_left[l]--;
          seq++;
          d = W'(seq) & 32'h7fff_ffff;
          d[W-1] = (pkt_left[l] == 0);
          push(l, d);
        end
      end
      cycle($urandom_range(0, 3) != 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/lane_arbiter.md
LANE_ARBITER -- requirements
Module: lane_arbiter

Interface
REQ-001 SHALL have parameter LANES, default 2, number of virtual lanes in the upstream multilane FIFO (LANES >= 2).
REQ-002 SHALL have parameter DATA_WIDTH, default 32, flit width; bit DATA_WIDTH-1 is the tail flag.
REQ-003 SHALL have derived parameter LANE_BITS = $clog2(LANES).
REQ-004 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port empty  input  LANES  per-lane empty flags from the FIFO.
REQ-007 SHALL have port din  input  DATA_WIDTH  head flit of lane pop_lane, combinational from the FIFO.
REQ-008 SHALL have port pop_lane  output  LANE_BITS  lane whose head is presented on din and popped.
REQ-009 SHALL have port pop  output  1  pops the head of pop_lane at the next rising edge.
REQ-010 SHALL have port out_data  output  DATA_WIDTH  registered flit to the downstream link.
REQ-011 SHALL have port out_lane  output  LANE_BITS  lane that out_data came from.
REQ-012 SHALL have port out_valid  output  1  out_data holds a flit.
REQ-013 SHALL have port out_ready  input  1  downstream accepts out_data this cycle.

Function
REQ-014 SHALL implement a one-entry output register; a transfer occurs on any edge where out_valid && out_ready.
REQ-015 SHALL define space = !out_valid || out_ready.
REQ-016 SHALL drive pop and pop_lane combinationally from the current state, the empty flags and space.
REQ-017 SHALL keep pop = 0 whenever empty[pop_lane] = 1; pop SHALL never target an empty lane.
REQ-018 SHALL, on an edge where pop = 1, load out_data <= din and out_lane <= pop_lane, and set out_valid = 1.
REQ-019 SHALL, on an edge where out_valid && out_ready && !pop, clear out_valid.
REQ-020 SHALL give one-cycle latency: a flit popped at edge N is valid on out_data after edge N.
REQ-021 SHALL sustain one flit per cycle while out_ready = 1 and the selected lane is non-empty.
REQ-022 SHALL implement the FSM states IDLE and LOCKED, plus a register lock_lane and a round-robin pointer last_grant.
REQ-023 SHALL, in IDLE, set pop_lane to the first non-empty lane searching (last_grant+1) mod LANES upward with wrap-around; if all lanes are empty, pop_lane = (last_grant+1) mod LANES and pop = 0.
REQ-024 SHALL, in IDLE, assert pop when the chosen lane is non-empty and space = 1.
REQ-025 SHALL, in IDLE, when a flit is popped with tail = 0, go to LOCKED with lock_lane = pop_lane.
REQ-026 SHALL, in IDLE, when a flit is popped with tail = 1 (single-flit packet), stay in IDLE with last_grant = pop_lane.
REQ-027 SHALL, in LOCKED, hold pop_lane = lock_lane and assert pop only when !empty[lock_lane] && space; other lanes SHALL NOT be served (wormhole).
REQ-028 SHALL, in LOCKED, when a tail flit is popped, return to IDLE with last_grant = lock_lane.
REQ-029 SHALL, in LOCKED, remain in LOCKED indefinitely while lock_lane is empty (no timeout).
REQ-030 SHALL hold out_data and out_lane stable while out_valid && !out_ready.

Reset
REQ-031 SHALL, while reset = 1, asynchronously force state = IDLE, last_grant = LANES-1 (lane 0 wins first), lock_lane = 0, out_valid = 0, out_data = 0 and out_lane = 0.
REQ-032 SHALL drive pop = 0 while reset = 1.
REQ-033 SHALL make any flit in flight when reset asserts mid-packet lost; no recovery is required.

Verification
REQ-034 SHALL cover reset: assert reset -> out_valid = 0, out_data = 0, pop = 0, pop_lane = 0.
REQ-035 SHALL cover round-robin: LANES = 2, both lanes hold single-flit packets (tail = 1) with values 0x80000001/0x80000002 and 0x80000011/0x80000012, out_ready = 1 -> out_lane sequence 0,1,0,1 and data 0x80000001, 0x80000011, 0x80000002, 0x80000012.
REQ-036 SHALL cover wormhole locking: lane 0 holds 0x1, 0x2, 0x80000003 and lane 1 holds 0x80000010 -> all three lane-0 flits are output before 0x80000010, which appears on the fourth valid cycle.
REQ-037 SHALL cover backpressure: out_ready = 0 for 3 cycles with out_valid = 1 -> pop = 0 and out_data stable for those cycles; out_ready = 1 -> one flit per cycle resumes with no loss or duplication.
REQ-038 SHALL cover stall in a locked lane: lane 0 sends non-tail 0x5 and then goes empty, while lane 1 is non-empty -> pop_lane stays 0 and pop = 0 until lane 0 refills.
REQ-039 SHALL cover reset mid-packet: reset asserted while LOCKED on lane 1 -> after release, state = IDLE and lane 0 is granted first.
